// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache between fetch and memctrl
//
// One instruction per line, keyed by halfword-aligned PC. Hits answer one
// cycle after acceptance with no memory traffic. Misses run the memctrl
// fetch handshake, fill the line and answer in the cycle after if_ready.
//
// Ports
//   clk_in, rst_in       clock, synchronous active-high reset
//   rdy_in               global ready; low freezes every register
//   clear                pipeline flush (only honoured while rdy_in=1)
//   req_valid/req_addr   fetch request; req_ready = idle and not clearing
//   resp_valid           one-cycle pulse with resp_addr/resp_inst/resp_is_c
//   if_enable/inst_addr  fetch request to memctrl while a miss is pending
//   if_ready/inst/is_c   memctrl reply, valid only in the if_ready cycle
module icache #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_inst,
    output logic        resp_is_c,
    output logic        if_enable,
    output logic [31:0] inst_addr,
    input  logic        if_ready,
    input  logic [31:0] inst,
    input  logic        is_c
);

    localparam int LINES = 1 << IDX_BITS;

    typedef enum logic {
        S_IDLE,
        S_MISS
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINES-1:0]    line_valid;
    logic [LINES-1:0]    line_c;
    logic [TAG_BITS-1:0] line_tag  [LINES];
    logic [31:0]         line_data [LINES];

    logic [31:0] miss_addr;

    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0] miss_tag;
    logic                hit;
    logic                accept;
    logic                fill;
    logic [31:0]         fill_data;

    assign req_idx  = req_addr[IDX_BITS:1];
    assign req_tag  = req_addr[IDX_BITS+TAG_BITS:IDX_BITS+1];
    assign miss_idx = miss_addr[IDX_BITS:1];
    assign miss_tag = miss_addr[IDX_BITS+TAG_BITS:IDX_BITS+1];

    assign hit       = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign accept    = rdy_in && req_valid && req_ready;
    // clear beats a simultaneous if_ready: the reply belongs to a flushed fetch
    assign fill      = rdy_in && (state == S_MISS) && if_ready && !clear;
    assign fill_data = is_c ? {16'b0, inst[15:0]} : inst;
    assign inst_addr = miss_addr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // if_enable drops in the if_ready cycle itself so memctrl, already back
    // in its idle state, does not launch a second fetch of the same PC.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        if_enable  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !clear;
                if (rdy_in && req_valid && !clear && !hit) begin
                    state_next = S_MISS;
                end
            end
            S_MISS: begin
                if_enable = !if_ready;
                if (rdy_in && (clear || if_ready)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            line_valid <= '0;
            miss_addr  <= '0;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_inst  <= '0;
            resp_is_c  <= 1'b0;
        end else if (rdy_in) begin
            resp_valid <= 1'b0;
            if (accept) begin
                if (hit) begin
                    resp_valid <= 1'b1;
                    resp_addr  <= req_addr;
                    resp_inst  <= line_data[req_idx];
                    resp_is_c  <= line_c[req_idx];
                end else begin
                    miss_addr <= req_addr;
                end
            end else if (fill) begin
                line_valid[miss_idx] <= 1'b1;
                resp_valid           <= 1'b1;
                resp_addr            <= miss_addr;
                resp_inst            <= fill_data;
                resp_is_c            <= is_c;
            end
        end
    end

    // Payload arrays carry no reset; line_valid alone decides whether they count.
    always_ff @(posedge clk_in) begin
        if (!rst_in && fill) begin
            line_tag[miss_idx]  <= miss_tag;
            line_data[miss_idx] <= fill_data;
            line_c[miss_idx]    <= is_c;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache
module tb_icache;

    localparam int IDX_BITS = 6;
    localparam int TAG_BITS = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_addr;
    logic [31:0] resp_inst;
    logic        resp_is_c;
    logic        if_enable;
    logic [31:0] inst_addr;
    logic        if_ready;
    logic [31:0] inst;
    logic        is_c;

    always #5 clk_in = ~clk_in;

    icache #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_addr  (resp_addr),
        .resp_inst  (resp_inst),
        .resp_is_c  (resp_is_c),
        .if_enable  (if_enable),
        .inst_addr  (inst_addr),
        .if_ready   (if_ready),
        .inst       (inst),
        .is_c       (is_c)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: which PC currently owns each line (last fill wins).
    logic [31:0] owner [int];

    typedef struct {
        logic [31:0] pc;
        bit          hit;
        int          delay;
        logic [31:0] exp_inst;
        bit          exp_c;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Synthetic program memory; compressed words carry junk in [31:16].
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        if (pc == 32'h0) return 32'h0050_0093;
        if (pc == 32'h102) return 32'hABCD_4505;
        return {pc[15:0] ^ 16'hC3A5, pc[15:0]};
    endfunction

    function automatic bit mem_c(input logic [31:0] pc);
        if (pc == 32'h0) return 1'b0;
        return pc[1];
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word(pc);
        return mem_c(pc) ? {16'h0, w[15:0]} : w;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 1) % (1 << IDX_BITS));
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return owner.exists(i) && owner[i] == pc;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // mode 0: normal fill, 1: clear before if_ready, 2: clear with if_ready
    task automatic do_fetch(input logic [31:0] pc, input bit exp_hit, input int delay,
                            input int mode, input logic [31:0] e_inst, input bit e_c);
        req_valid = 1'b1;
        req_addr  = pc;
        #1;
        check1("req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        if (exp_hit) begin
            check1("hit_valid", resp_valid, 1'b1);
            check32("hit_addr", resp_addr, pc);
            check32("hit_inst", resp_inst, e_inst);
            check1("hit_is_c", resp_is_c, e_c);
            check1("hit_no_if_enable", if_enable, 1'b0);
        end else begin
            check1("miss_no_resp", resp_valid, 1'b0);
            check1("miss_if_enable", if_enable, 1'b1);
            check32("miss_inst_addr", inst_addr, pc);
            for (int k = 0; k < delay; k++) begin
                tick();
                check1("miss_wait_if_enable", if_enable, 1'b1);
            end
            if (mode == 1) begin
                clear = 1'b1;
            end else begin
                if_ready = 1'b1;
                inst     = mem_word(pc);
                is_c     = mem_c(pc);
                if (mode == 2) clear = 1'b1;
                #1;
                check1("if_enable_drop", if_enable, 1'b0);
            end
            tick();
            clear    = 1'b0;
            if_ready = 1'b0;
            inst     = 32'h0;
            is_c     = 1'b0;
            if (mode == 0) begin
                check1("fill_valid", resp_valid, 1'b1);
                check32("fill_addr", resp_addr, pc);
                check32("fill_inst", resp_inst, e_inst);
                check1("fill_is_c", resp_is_c, e_c);
                owner[idx_of(pc)] = pc;
            end else begin
                check1("abort_no_resp", resp_valid, 1'b0);
                check1("abort_idle", if_enable, 1'b0);
            end
        end
    endtask

    initial begin
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        clear     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        if_ready  = 1'b0;
        inst      = 32'h0;
        is_c      = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;

        check1("rst_resp_valid", resp_valid, 1'b0);
        check32("rst_resp_addr", resp_addr, 32'h0);
        check32("rst_resp_inst", resp_inst, 32'h0);
        check1("rst_resp_is_c", resp_is_c, 1'b0);
        check1("rst_if_enable", if_enable, 1'b0);
        check32("rst_inst_addr", inst_addr, 32'h0);
        check1("rst_req_ready", req_ready, 1'b1);

        // Cold miss, hit, compressed fill, index conflicts.
        vecs.push_back('{32'h0000_0000, 1'b0, 3, 32'h0050_0093, 1'b0});
        vecs.push_back('{32'h0000_0000, 1'b1, 0, 32'h0050_0093, 1'b0});
        vecs.push_back('{32'h0000_0102, 1'b0, 0, 32'h0000_4505, 1'b1});
        vecs.push_back('{32'h0000_0102, 1'b1, 0, 32'h0000_4505, 1'b1});
        vecs.push_back('{32'h0000_0004, 1'b0, 1, 32'hC3A1_0004, 1'b0});
        vecs.push_back('{32'h0000_0084, 1'b0, 2, 32'hC321_0084, 1'b0});
        vecs.push_back('{32'h0000_0004, 1'b0, 0, 32'hC3A1_0004, 1'b0});
        vecs.push_back('{32'h0000_0004, 1'b1, 0, 32'hC3A1_0004, 1'b0});
        vecs.push_back('{32'h0000_0084, 1'b0, 0, 32'hC321_0084, 1'b0});
        foreach (vecs[i]) begin
            do_fetch(vecs[i].pc, vecs[i].hit, vecs[i].delay, 0, vecs[i].exp_inst, vecs[i].exp_c);
        end

        // Four back-to-back hits give four consecutive pulses, then silence.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check1("b2b_valid", resp_valid, 1'b1);
            check1("b2b_no_if_enable", if_enable, 1'b0);
        end
        req_valid = 1'b0;
        tick();
        check1("b2b_pulse_end", resp_valid, 1'b0);

        // clear blocks acceptance in IDLE.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        clear     = 1'b1;
        #1;
        check1("clear_req_ready", req_ready, 1'b0);
        tick();
        clear     = 1'b0;
        req_valid = 1'b0;
        check1("clear_no_resp", resp_valid, 1'b0);

        // clear during MISS, before and together with if_ready.
        do_fetch(32'h210, 1'b0, 2, 1, 32'h0, 1'b0);
        do_fetch(32'h210, 1'b0, 0, 0, exp_inst(32'h210), mem_c(32'h210));
        do_fetch(32'h320, 1'b0, 1, 2, 32'h0, 1'b0);
        do_fetch(32'h320, 1'b0, 0, 0, exp_inst(32'h320), mem_c(32'h320));

        // rdy_in low mid-MISS: handshake frozen, clear ignored.
        req_valid = 1'b1;
        req_addr  = 32'h440;
        tick();
        req_valid = 1'b0;
        rdy_in    = 1'b0;
        clear     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("frz_miss_if_enable", if_enable, 1'b1);
            check1("frz_miss_no_resp", resp_valid, 1'b0);
            check32("frz_miss_inst_addr", inst_addr, 32'h440);
        end
        clear    = 1'b0;
        rdy_in   = 1'b1;
        if_ready = 1'b1;
        inst     = mem_word(32'h440);
        is_c     = mem_c(32'h440);
        tick();
        if_ready = 1'b0;
        check1("frz_miss_resp", resp_valid, 1'b1);
        check32("frz_miss_inst", resp_inst, exp_inst(32'h440));
        owner[idx_of(32'h440)] = 32'h440;

        // rdy_in low after a hit accept: response held, new requests ignored.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        rdy_in   = 1'b0;
        req_addr = 32'h102;
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("frz_hit_valid", resp_valid, 1'b1);
            check32("frz_hit_addr", resp_addr, 32'h0);
            check32("frz_hit_inst", resp_inst, 32'h0050_0093);
        end
        req_valid = 1'b0;
        rdy_in    = 1'b1;
        tick();
        check1("frz_hit_release", resp_valid, 1'b0);

        // Reset mid-MISS invalidates every line.
        req_valid = 1'b1;
        req_addr  = 32'h500;
        tick();
        req_valid = 1'b0;
        rst_in    = 1'b1;
        tick();
        rst_in = 1'b0;
        check1("rst_miss_if_enable", if_enable, 1'b0);
        check1("rst_miss_req_ready", req_ready, 1'b1);
        owner.delete();
        do_fetch(32'h0, 1'b0, 0, 0, 32'h0050_0093, 1'b0);

        // Randomised traffic over a small aliasing PC pool.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] pc;
            int          mode;
            pc   = $urandom & 32'h0001_8086;
            mode = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 14) == 0) ? 2 : 0);
            do_fetch(pc, model_hit(pc), int'($urandom_range(0, 3)), mode, exp_inst(pc), mem_c(pc));
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
